// File: rtl/alu_share_pkg.sv
// Shared types and default widths for the two-requester ALU sharing controller.
package alu_share_pkg;

  localparam int unsigned DW_DEF  = 4;
  localparam int unsigned OPW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_arb.sv
// Grant logic for the two requesters: round-robin when ALU_SHARE_RR_EN is defined,
// otherwise fixed priority with requester 0 winning contention.
module alu_share_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

`ifdef ALU_SHARE_RR_EN
  // ptr_q holds the index of the requester served by the last accept
  logic ptr_q;
  logic ptr_d;

  // One-hot grant: contention goes to the requester not served last
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  // Pointer moves only when a grant is actually accepted
  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) begin
      ptr_d = grant_o[1];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; reset value makes requester 0 win first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_s;
  assign unused_s = &{1'b0, clk, rst_n, accept_i};

  // Fixed priority: requester 0 always wins
  always_comb begin
    grant_o = 2'b00;
    if (valid_i[0]) begin
      grant_o = 2'b01;
    end else if (valid_i[1]) begin
      grant_o = 2'b10;
    end else begin
      grant_o = 2'b00;
    end
  end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Two requesters share one external combinational ALU: IDLE accepts, EXEC lets the
// ALU settle, RESP captures nothing new and pulses rspN_valid on the way back to IDLE.
// Arbitration mode selected by macro ALU_SHARE_RR_EN (see alu_share_arb).
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic           req1_valid,
  output logic           req0_ready,
  output logic           req1_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  output logic [DW:0]    rsp0_data,
  output logic [DW:0]    rsp1_data,
  output logic [OPW-1:0] alu_st,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic [DW:0]    alu_out,
  output logic           busy
);

  state_e         state_q;
  logic [1:0]     gnt_q;
  logic [1:0]     rsp_valid_q;
  logic [DW:0]    rsp0_data_q;
  logic [DW:0]    rsp1_data_q;
  logic [OPW-1:0] alu_st_q;
  logic [DW-1:0]  alu_a_q;
  logic [DW-1:0]  alu_b_q;

  logic [1:0]     grant_s;
  logic [1:0]     ready_s;
  logic           accept_s;

  alu_share_arb u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept_i (accept_s),
    .valid_i  ({req1_valid, req0_valid}),
    .grant_o  (grant_s)
  );

  // Ready only in IDLE; valids seen in EXEC/RESP are ignored
  always_comb begin
    ready_s = 2'b00;
    if (state_q == IDLE) begin
      ready_s = grant_s & {req1_valid, req0_valid};
    end else begin
      ready_s = 2'b00;
    end
  end

  assign accept_s = |ready_s;

  // Transaction FSM with its registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp0_data_q <= {(DW+1){1'b0}};
      rsp1_data_q <= {(DW+1){1'b0}};
      alu_st_q    <= {OPW{1'b0}};
      alu_a_q     <= {DW{1'b0}};
      alu_b_q     <= {DW{1'b0}};
    end else begin
      rsp_valid_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_q  <= EXEC;
            gnt_q    <= ready_s;
            alu_st_q <= ready_s[1] ? req1_op : req0_op;
            alu_a_q  <= ready_s[1] ? req1_a  : req0_a;
            alu_b_q  <= ready_s[1] ? req1_b  : req0_b;
          end else begin
            state_q  <= IDLE;
          end
        end
        EXEC: begin
          state_q <= RESP;
          if (gnt_q[0]) begin
            rsp0_data_q <= alu_out;
          end
          if (gnt_q[1]) begin
            rsp1_data_q <= alu_out;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= gnt_q;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = ready_s[0];
  assign req1_ready = ready_s[1];
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign alu_st     = alu_st_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl; expectations follow ALU_SHARE_RR_EN if defined.
module tb_alu_share_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp1_valid;
  logic [4:0] rsp0_data, rsp1_data;
  logic [3:0] alu_st, alu_a, alu_b;
  logic [4:0] alu_out;
  logic       busy;

  int n_cmp;
  int n_err;

  alu_share_ctrl #(.DW(4), .OPW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp0_data  (rsp0_data),
    .rsp1_data  (rsp1_data),
    .alu_st     (alu_st),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: 1 = add, 2 = subtract (DW+1-bit wrap), otherwise xor
  always_comb begin
    case (alu_st)
      4'd1:    alu_out = {1'b0, alu_a} + {1'b0, alu_b};
      4'd2:    alu_out = {1'b0, alu_a} - {1'b0, alu_b};
      default: alu_out = {1'b0, alu_a ^ alu_b};
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_rdy2;
  logic       exp_rv0, exp_rv1;
  logic [4:0] exp_d0, exp_d1;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 4'd0; req0_a = 4'd0; req0_b = 4'd0;
    req1_op = 4'd0; req1_a = 4'd0; req1_b = 4'd0;
    #2;
    check_eq("rst_busy",   busy, 1'b0);
    check_eq("rst_rspv",   {rsp1_valid, rsp0_valid}, 2'b00);
    check_eq("rst_data",   {rsp1_data, rsp0_data}, 10'h000);
    check_eq("rst_alu",    {alu_st, alu_a, alu_b}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 0: 3 + 5 = 8
    req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 4'h3; req0_b = 4'h5;
    #1;
    check_eq("r0_ready",  {req1_ready, req0_ready}, 2'b01);
    tick();
    req0_valid = 1'b0;
    check_eq("r0_alu",    {alu_st, alu_a, alu_b}, 12'h135);
    check_eq("r0_busy_exec", busy, 1'b1);
    tick();
    check_eq("r0_data",   rsp0_data, 5'h08);
    check_eq("r0_v_early", rsp0_valid, 1'b0);
    tick();
    check_eq("r0_v_pulse", {rsp1_valid, rsp0_valid}, 2'b01);
    check_eq("r0_busy_idle", busy, 1'b0);
    tick();
    check_eq("r0_v_end",  {rsp1_valid, rsp0_valid}, 2'b00);

    // Data isolation: req0 gets 0 - 1 = 1F, then req1 gets 1 + 1 = 02
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 4'h0; req0_b = 4'h1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    check_eq("iso_d0",    rsp0_data, 5'h1F);
    req1_valid = 1'b1; req1_op = 4'd1; req1_a = 4'h1; req1_b = 4'h1;
    tick();
    req1_valid = 1'b0;
    check_eq("iso_d0_exec", rsp0_data, 5'h1F);
    tick();
    check_eq("iso_d1",    rsp1_data, 5'h02);
    check_eq("iso_d0_resp", rsp0_data, 5'h1F);
    tick();
    check_eq("iso_v",     {rsp1_valid, rsp0_valid}, 2'b10);
    check_eq("iso_d0_end", rsp0_data, 5'h1F);

    // Contention from reset, both held for two transactions
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 4'd1; req0_a = 4'h2; req0_b = 4'h2;
    req1_valid = 1'b1; req1_op = 4'd1; req1_a = 4'h7; req1_b = 4'h1;
    #1;
    check_eq("ct_first",  {req1_ready, req0_ready}, 2'b01);
    tick();
    check_eq("ct_rdy_exec", {req1_ready, req0_ready}, 2'b00);
    tick();
    check_eq("ct_rdy_resp", {req1_ready, req0_ready}, 2'b00);
    check_eq("ct_d0",     rsp0_data, 5'h04);
    tick();
    check_eq("ct_v0",     rsp0_valid, 1'b1);
`ifdef ALU_SHARE_RR_EN
    exp_rdy2 = 2'b10; exp_rv0 = 1'b0; exp_rv1 = 1'b1; exp_d1 = 5'h08;
`else
    exp_rdy2 = 2'b01; exp_rv0 = 1'b1; exp_rv1 = 1'b0; exp_d1 = 5'h00;
`endif
    exp_d0 = 5'h04;
    check_eq("ct_second", {req1_ready, req0_ready}, exp_rdy2);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    tick();
    check_eq("ct_rv",     {rsp1_valid, rsp0_valid}, {exp_rv1, exp_rv0});
    check_eq("ct_data",   {rsp1_data, rsp0_data}, {exp_d1, exp_d0});

    // Back-to-back requester 1: accepts every third cycle
    req1_valid = 1'b1; req1_op = 4'd1; req1_a = 4'h3; req1_b = 4'h3;
    for (int k = 0; k < 9; k++) begin
      #1;
      check_eq($sformatf("b2b_busy_%0d", k), busy, (k % 3) != 0);
      check_eq($sformatf("b2b_rdy_%0d", k), {req1_ready, req0_ready}, ((k % 3) == 0) ? 2'b10 : 2'b00);
      if (k > 0 && (k % 3) == 0) begin
        check_eq($sformatf("b2b_rsp_%0d", k), {rsp1_valid, rsp1_data}, 6'h26);
      end
      tick();
    end
    req1_valid = 1'b0;
    tick();
    tick();
    tick();

    // Reset in EXEC drops the transaction
    req0_valid = 1'b1; req0_op = 4'd1; req0_a = 4'h1; req0_b = 4'h2;
    tick();
    req0_valid = 1'b0;
    check_eq("rx_busy",   busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("rx_busy0",  busy, 1'b0);
    check_eq("rx_alu0",   {alu_st, alu_a, alu_b}, 12'h000);
    check_eq("rx_data0",  {rsp1_data, rsp0_data}, 10'h000);
    check_eq("rx_rspv0",  {rsp1_valid, rsp0_valid}, 2'b00);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("rx_norsp_%0d", k), {rsp1_valid, rsp0_valid}, 2'b00);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check_eq("rx_first",  {req1_ready, req0_ready}, 2'b01);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
